// File: rtl/regs_wb_pkg.sv
// ============================================================================
// regs_wb_pkg : shared constants and types for the regs_wb write-back slice
// Rev 1.0
// ============================================================================
`default_nettype none

package regs_wb_pkg;

   localparam int REGS_DATA_WIDTH = 32;
   localparam int REGS_ADDR_WIDTH = 5;
   localparam int REGS_NUM        = 32;
   localparam logic [REGS_ADDR_WIDTH-1:0] REGS_ZERO_REG  = 5'd0;
   localparam logic                       WRITE_ENABLE   = 1'b1;
   localparam logic                       WRITE_DISABLE  = 1'b0;

   typedef enum logic [0:0] {
      WB_EMPTY = 1'b0,
      WB_PEND  = 1'b1
   } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/regs_wb_buf.sv
// ============================================================================
// regs_wb_buf : one-entry write-back holding register (capture/commit/ready)
// Rev 1.0
// ============================================================================
`default_nettype none

module regs_wb_buf
   import regs_wb_pkg::*;
#(
   parameter int DATA_W = REGS_DATA_WIDTH,
   parameter int ADDR_W = REGS_ADDR_WIDTH
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              dbg_we_i,
   output logic              wb_ready_o,
   output logic              commit_o,
   output logic              wb_valid_o,
   output logic [ADDR_W-1:0] wb_addr_o,
   output logic [DATA_W-1:0] wb_data_o
);

   wb_state_e         state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              capture;

   assign wb_valid_o = (state_q == WB_PEND);
   // A debug write owns the array port, so a pending entry must wait.
   assign commit_o   = wb_valid_o & ~dbg_we_i;
   assign wb_ready_o = ~rst_i & (~wb_valid_o | commit_o);
   assign capture    = we_i & wb_ready_o & (waddr_i != {ADDR_W{1'b0}});
   assign wb_addr_o  = addr_q;
   assign wb_data_o  = data_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= WB_EMPTY;
         addr_q  <= '0;
         data_q  <= '0;
      end else if (capture) begin
         state_q <= WB_PEND;
         addr_q  <= waddr_i;
         data_q  <= wdata_i;
      end else if (commit_o) begin
         state_q <= WB_EMPTY;
      end
   end

endmodule

`default_nettype wire

// File: rtl/regs_wb.sv
// ============================================================================
// regs_wb : 32x32 integer register file with buffered write-back and debug port
// Optional read bypass of the pending entry: REGS_WB_BYPASS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module regs_wb
   import regs_wb_pkg::*;
#(
   parameter int DATA_W  = REGS_DATA_WIDTH,
   parameter int ADDR_W  = REGS_ADDR_WIDTH,
   parameter int REG_NUM = REGS_NUM
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              wb_ready_o,
   input  logic [ADDR_W-1:0] raddr1_i,
   output logic [DATA_W-1:0] rdata1_o,
   input  logic [ADDR_W-1:0] raddr2_i,
   output logic [DATA_W-1:0] rdata2_o,
   input  logic              dbg_we_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [DATA_W-1:0] dbg_wdata_i,
   output logic [DATA_W-1:0] dbg_rdata_o
);

   logic [DATA_W-1:0] regs_q [REG_NUM];
   logic              commit;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              wr_en_d;
   logic [ADDR_W-1:0] wr_addr_d;
   logic [DATA_W-1:0] wr_data_d;

   regs_wb_buf #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_buf (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .we_i       (we_i),
      .waddr_i    (waddr_i),
      .wdata_i    (wdata_i),
      .dbg_we_i   (dbg_we_i),
      .wb_ready_o (wb_ready_o),
      .commit_o   (commit),
      .wb_valid_o (wb_valid),
      .wb_addr_o  (wb_addr),
      .wb_data_o  (wb_data)
   );

   // Single array write port: debug first, core entry otherwise; x0 is never written.
   always_comb begin
      wr_en_d   = WRITE_DISABLE;
      wr_addr_d = wb_addr;
      wr_data_d = wb_data;
      if (dbg_we_i) begin
         wr_en_d   = (dbg_addr_i != REGS_ZERO_REG);
         wr_addr_d = dbg_addr_i;
         wr_data_d = dbg_wdata_i;
      end else if (commit) begin
         wr_en_d   = WRITE_ENABLE;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      end else if (wr_en_d) begin
         regs_q[wr_addr_d] <= wr_data_d;
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
      if (a == REGS_ZERO_REG) return '0;
`ifdef REGS_WB_BYPASS_EN
      if (wb_valid && (a == wb_addr)) return wb_data;
`endif
      return regs_q[a];
   endfunction

   always_comb begin
      rdata1_o    = read_port(raddr1_i);
      rdata2_o    = read_port(raddr2_i);
      dbg_rdata_o = (dbg_addr_i == REGS_ZERO_REG) ? '0 : regs_q[dbg_addr_i];
   end

`ifndef REGS_WB_BYPASS_EN
   logic unused_valid;
   assign unused_valid = wb_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regs_wb.sv
// ============================================================================
// tb_regs_wb : directed self-checking bench for regs_wb with a commit scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regs_wb;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [31:0] wdata_i;
   logic        wb_ready_o;
   logic [4:0]  raddr1_i, raddr2_i;
   logic [31:0] rdata1_o, rdata2_o;
   logic        dbg_we_i;
   logic [4:0]  dbg_addr_i;
   logic [31:0] dbg_wdata_i;
   logic [31:0] dbg_rdata_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } sb_t;
   sb_t sb_q[$];

   regs_wb dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .we_i        (we_i),
      .waddr_i     (waddr_i),
      .wdata_i     (wdata_i),
      .wb_ready_o  (wb_ready_o),
      .raddr1_i    (raddr1_i),
      .rdata1_o    (rdata1_o),
      .raddr2_i    (raddr2_i),
      .rdata2_o    (rdata2_o),
      .dbg_we_i    (dbg_we_i),
      .dbg_addr_i  (dbg_addr_i),
      .dbg_wdata_i (dbg_wdata_i),
      .dbg_rdata_o (dbg_rdata_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drain_scoreboard();
      sb_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         raddr1_i   = e.addr;
         raddr2_i   = e.addr;
         dbg_addr_i = e.addr;
         #1;
         check($sformatf("sb_rd1_x%0d", e.addr), rdata1_o, e.data);
         check($sformatf("sb_rd2_x%0d", e.addr), rdata2_o, e.data);
         check($sformatf("sb_dbg_x%0d", e.addr), dbg_rdata_o, e.data);
      end
   endtask

   initial begin
      rst_i = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0;
      raddr1_i = '0; raddr2_i = '0;
      dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
      tick(); tick();
      raddr1_i = 5'd3; raddr2_i = 5'd9;
      #1;
      check("rst_ready", {31'd0, wb_ready_o}, 32'd0);
      check("rst_rd1", rdata1_o, 32'd0);
      rst_i = 1'b0;
      #1;
      check("post_rst_ready", {31'd0, wb_ready_o}, 32'd1);

      // single write, read-after-write latency
      we_i = 1'b1; waddr_i = 5'd5; wdata_i = 32'hDEADBEEF; raddr1_i = 5'd5;
      #1;
      check("raw_accept_cycle", rdata1_o, 32'd0);
      tick();
      we_i = 1'b0;
      #1;
`ifdef REGS_WB_BYPASS_EN
      check("raw_after_capture", rdata1_o, 32'hDEADBEEF);
`else
      check("raw_after_capture", rdata1_o, 32'd0);
`endif
      tick();
      check("raw_after_commit", rdata1_o, 32'hDEADBEEF);

      // back-to-back writes at full throughput
      for (int i = 1; i <= 3; i++) begin
         we_i = 1'b1; waddr_i = 5'(i); wdata_i = 32'(i);
         #1;
         check($sformatf("b2b_ready_%0d", i), {31'd0, wb_ready_o}, 32'd1);
         sb_q.push_back('{addr: 5'(i), data: 32'(i)});
         tick();
      end
      we_i = 1'b0;
      tick(); tick();
      drain_scoreboard();

      // debug stall while an entry is pending
      we_i = 1'b1; waddr_i = 5'd4; wdata_i = 32'h11;
      tick();
      waddr_i = 5'd8; wdata_i = 32'h88;
      dbg_we_i = 1'b1; dbg_addr_i = 5'd7; dbg_wdata_i = 32'h77;
      #1;
      check("stall_ready_low", {31'd0, wb_ready_o}, 32'd0);
      tick();
      dbg_we_i = 1'b0;
      #1;
      check("stall_dbg_x7", dbg_rdata_o, 32'h77);
      check("stall_release_ready", {31'd0, wb_ready_o}, 32'd1);
      tick();
      we_i = 1'b0; dbg_addr_i = 5'd4;
      #1;
      check("stall_x4_committed", dbg_rdata_o, 32'h11);
      tick();
      sb_q.push_back('{addr: 5'd7, data: 32'h77});
      sb_q.push_back('{addr: 5'd4, data: 32'h11});
      sb_q.push_back('{addr: 5'd8, data: 32'h88});
      drain_scoreboard();

      // same-address debug write: core data wins
      we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'hAAAA;
      tick();
      we_i = 1'b0;
      dbg_we_i = 1'b1; dbg_addr_i = 5'd9; dbg_wdata_i = 32'h5555;
      #1;
      check("same_addr_ready_low", {31'd0, wb_ready_o}, 32'd0);
      tick();
      dbg_we_i = 1'b0;
      #1;
      check("same_addr_dbg_first", dbg_rdata_o, 32'h5555);
      tick();
      check("same_addr_core_final", dbg_rdata_o, 32'hAAAA);
      sb_q.push_back('{addr: 5'd9, data: 32'hAAAA});
      drain_scoreboard();

      // x0 writes are dropped
      we_i = 1'b1; waddr_i = 5'd0; wdata_i = 32'hFFFFFFFF;
      dbg_we_i = 1'b1; dbg_addr_i = 5'd0; dbg_wdata_i = 32'hFFFFFFFF;
      raddr1_i = 5'd0; raddr2_i = 5'd0;
      #1;
      check("x0_ready", {31'd0, wb_ready_o}, 32'd1);
      tick();
      we_i = 1'b0;
      #1;
      check("x0_no_entry_ready", {31'd0, wb_ready_o}, 32'd1);
      check("x0_rd1", rdata1_o, 32'd0);
      check("x0_rd2", rdata2_o, 32'd0);
      check("x0_dbg", dbg_rdata_o, 32'd0);
      dbg_we_i = 1'b0;
      tick();

      // asynchronous reset discards a pending entry
      we_i = 1'b1; waddr_i = 5'd6; wdata_i = 32'h1234;
      raddr1_i = 5'd6; raddr2_i = 5'd5; dbg_addr_i = 5'd5;
      tick();
      we_i = 1'b0;
      #3;
      rst_i = 1'b1;
      #1;
      check("arst_rd1", rdata1_o, 32'd0);
      check("arst_rd2_x5", rdata2_o, 32'd0);
      check("arst_dbg_x5", dbg_rdata_o, 32'd0);
      check("arst_ready", {31'd0, wb_ready_o}, 32'd0);
      tick(); tick();
      rst_i = 1'b0;
      #1;
      check("arst_release_ready", {31'd0, wb_ready_o}, 32'd1);
      tick();
      check("arst_x6_discarded", rdata1_o, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
